// File: rtl/cvxif_dotp_pkg.sv
// cvxif_dotp_pkg: decode constants, op enum, pipeline stage types and int8 multiply helper for cvxif_dotp_unit
package cvxif_dotp_pkg;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_DOTP = 3'b000;
  localparam int ID_W = 4;
  typedef enum logic [6:0] {
    OP_DOTP    = 7'd0,
    OP_DOTPACC = 7'd1,
    OP_ACCCLR  = 7'd2
  } op_e;
  typedef struct packed {
    logic            valid;
    op_e             op;
    logic [4:0]      rd;
    logic [ID_W-1:0] id;
    logic [3:0][15:0] prod;
  } s1_t;
  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } s2_t;
  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return sa * sb;
  endfunction
endpackage

// File: rtl/cvxif_dotp_decode.sv
// cvxif_dotp_decode: combinational custom-0 decoder; i_instr -> o_accept, o_op (funct7), o_rd
module cvxif_dotp_decode
  import cvxif_dotp_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_accept,
  output op_e         o_op,
  output logic [4:0]  o_rd
);
  logic w_unused_rs;
  assign w_unused_rs = ^i_instr[24:15];
  assign o_op = op_e'(i_instr[31:25]);
  assign o_rd = i_instr[11:7];
  assign o_accept = (i_instr[6:0] == OPC_CUSTOM0) && (i_instr[14:12] == F3_DOTP) &&
                    (o_op == OP_DOTP || o_op == OP_DOTPACC || o_op == OP_ACCCLR);
endmodule

// File: rtl/cvxif_dotp_unit.sv
// cvxif_dotp_unit: CV-X-IF packed int8 dot-product coprocessor, 2-stage in-order pipeline with 32-bit accumulator
// Ports: issue channel (valid/ready/instr/rs1/rs2/id, accept/writeback), result channel (valid/ready/data/rd/id/we),
// flush_i kills in-flight work. Define CVXIF_DOTP_SAT_EN to saturate DOTPACC accumulation instead of wrapping.
// IdWidth must not exceed cvxif_dotp_pkg::ID_W (the stage storage width).
module cvxif_dotp_unit
  import cvxif_dotp_pkg::*;
#(
  parameter int IdWidth = ID_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [31:0]        issue_rs1_i,
  input  logic [31:0]        issue_rs2_i,
  input  logic [IdWidth-1:0] issue_id_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [31:0]        result_data_o,
  output logic [4:0]         result_rd_o,
  output logic [IdWidth-1:0] result_id_o,
  output logic               result_we_o
);
  s1_t              r_s1;
  s2_t              r_s2;
  logic [31:0]      r_acc;
  logic             r_rdy;
  logic             w_accept, w_s2_load, w_s1_en, w_issue;
  op_e              w_op;
  logic [4:0]       w_rd;
  logic [3:0][15:0] w_prod;
  logic signed [17:0] w_sum;
  logic [31:0]      w_dotp, w_acc_new, w_s2_data;
  cvxif_dotp_decode u_dec (
    .i_instr  (issue_instr_i),
    .o_accept (w_accept),
    .o_op     (w_op),
    .o_rd     (w_rd)
  );
  for (genvar i = 0; i < 4; i++) begin : g_mul
    assign w_prod[i] = mul8(issue_rs1_i[8*i +: 8], issue_rs2_i[8*i +: 8]);
  end
  assign w_s2_load = !r_s2.valid || result_ready_i;
  assign w_s1_en = !r_s1.valid || w_s2_load;
  // r_rdy keeps issue_ready_o low while reset is held and for the release cycle
  assign issue_ready_o = r_rdy && !flush_i && w_s1_en;
  assign w_issue = issue_valid_i && issue_ready_o && w_accept;
  assign issue_accept_o = w_accept;
  assign issue_writeback_o = w_accept;
  assign result_valid_o = r_s2.valid;
  assign result_we_o = r_s2.valid;
  assign result_data_o = r_s2.data;
  assign result_rd_o = r_s2.rd;
  assign result_id_o = IdWidth'(r_s2.id);
  always_comb begin
    w_sum = 18'($signed(r_s1.prod[0])) + 18'($signed(r_s1.prod[1])) +
            18'($signed(r_s1.prod[2])) + 18'($signed(r_s1.prod[3]));
    w_dotp = 32'(w_sum);
`ifdef CVXIF_DOTP_SAT_EN
    begin
      logic [32:0] w_acc_sum;
      w_acc_sum = {r_acc[31], r_acc} + {w_dotp[31], w_dotp};
      w_acc_new = (w_acc_sum[32] != w_acc_sum[31]) ? (w_acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                                    : w_acc_sum[31:0];
    end
`else
    w_acc_new = r_acc + w_dotp;
`endif
    w_s2_data = (r_s1.op == OP_DOTP) ? w_dotp : (r_s1.op == OP_DOTPACC) ? w_acc_new : r_acc;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_acc <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (flush_i) begin
        r_s1.valid <= 1'b0;
        r_s2.valid <= 1'b0;
      end else begin
        if (w_s1_en)
          r_s1 <= '{valid: w_issue, op: w_op, rd: w_rd, id: ID_W'(issue_id_i), prod: w_prod};
        if (w_s2_load)
          r_s2 <= '{valid: r_s1.valid, rd: r_s1.rd, id: r_s1.id, data: w_s2_data};
        if (w_s2_load && r_s1.valid && r_s1.op != OP_DOTP)
          r_acc <= (r_s1.op == OP_DOTPACC) ? w_acc_new : '0;
      end
    end
  end
endmodule

// File: tb/tb_cvxif_dotp_unit.sv
// tb_cvxif_dotp_unit: directed self-checking bench for cvxif_dotp_unit
module tb_cvxif_dotp_unit;
  localparam int IDW = 4;
  logic clk = 1'b0, rst_i = 1'b1, flush_i = 1'b0, issue_valid_i = 1'b0, result_ready_i = 1'b0;
  logic [31:0] issue_instr_i = '0, issue_rs1_i = '0, issue_rs2_i = '0;
  logic [IDW-1:0] issue_id_i = '0;
  logic issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o, result_we_o;
  logic [31:0] result_data_o;
  logic [4:0] result_rd_o;
  logic [IDW-1:0] result_id_o;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  cvxif_dotp_unit #(.IdWidth(IDW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .issue_id_i(issue_id_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_id_o(result_id_o), .result_we_o(result_we_o)
  );
  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rd);
    return {f7, 10'd0, 3'b000, rd, 7'b0001011};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [IDW-1:0] id, input logic [31:0] exp);
    int n;
    issue_instr_i = mk(f7, rd);
    issue_rs1_i = a;
    issue_rs2_i = b;
    issue_id_i = id;
    issue_valid_i = 1'b1;
    #1;
    n = 0;
    while (!issue_ready_o && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_issue"}, {31'd0, issue_ready_o}, 32'd1);
    @(negedge clk);
    issue_valid_i = 1'b0;
    n = 0;
    while (!result_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_data"}, result_data_o, exp);
    chk({tag, "_rd"}, {27'd0, result_rd_o}, {27'd0, rd});
    chk({tag, "_id"}, {28'd0, result_id_o}, {28'd0, id});
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int nis, nres;
    logic seen;
    logic [31:0] first, last, big_exp;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, issue_ready_o}, 32'd0);
    chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("rst_data", result_data_o, 32'd0);
    chk("rst_we", {31'd0, result_we_o}, 32'd0);
    rst_i = 1'b0;
    result_ready_i = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'd0, issue_ready_o}, 32'd1);
    // latency: presented before edge t, visible in S2 after edge t+1
    issue_instr_i = mk(7'd0, 5'd5);
    issue_rs1_i = 32'h04030201;
    issue_rs2_i = 32'h01010101;
    issue_id_i = 4'd3;
    issue_valid_i = 1'b1;
    #1;
    chk("lat_accept", {31'd0, issue_accept_o}, 32'd1);
    chk("lat_wb", {31'd0, issue_writeback_o}, 32'd1);
    @(negedge clk);
    issue_valid_i = 1'b0;
    chk("lat_early", {31'd0, result_valid_o}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, result_valid_o}, 32'd1);
    chk("lat_we", {31'd0, result_we_o}, 32'd1);
    chk("lat_data", result_data_o, 32'h0000000A);
    chk("lat_rd", {27'd0, result_rd_o}, 32'd5);
    chk("lat_id", {28'd0, result_id_o}, 32'd3);
    @(negedge clk);
    chk("lat_drained", {31'd0, result_valid_o}, 32'd0);
    run_op("sgn_min", 7'd0, 32'h80808080, 32'h80808080, 5'd1, 4'd1, 32'h00010000);
    run_op("sgn_neg", 7'd0, 32'hFFFFFFFF, 32'h02020202, 5'd2, 4'd2, 32'hFFFFFFF8);
    run_op("acc1", 7'd1, 32'h01010101, 32'h01010101, 5'd3, 4'd4, 32'd4);
    run_op("acc2", 7'd1, 32'h01010101, 32'h01010101, 5'd3, 4'd5, 32'd8);
    run_op("acc3", 7'd1, 32'h01010101, 32'h01010101, 5'd3, 4'd6, 32'd12);
    run_op("accclr", 7'd2, 32'h0, 32'h0, 5'd4, 4'd7, 32'd12);
    run_op("acc_after_clr", 7'd1, 32'h01010101, 32'h01010101, 5'd3, 4'd8, 32'd4);
    issue_instr_i = 32'h00000033;
    issue_valid_i = 1'b1;
    #1;
    chk("unk_accept", {31'd0, issue_accept_o}, 32'd0);
    chk("unk_wb", {31'd0, issue_writeback_o}, 32'd0);
    chk("unk_ready", {31'd0, issue_ready_o}, 32'd1);
    @(negedge clk);
    issue_valid_i = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= result_valid_o;
    end
    chk("unk_nores", {31'd0, seen}, 32'd0);
    // backpressure: results 4,8,12,16 in id order, ready held low for cycles 0..4
    nis = 0;
    nres = 0;
    for (int c = 0; c < 30 && nres < 4; c++) begin
      @(negedge clk);
      issue_valid_i = (nis < 4);
      issue_instr_i = mk(7'd0, 5'(10 + nis));
      issue_rs1_i = 32'h01010101 * (nis + 1);
      issue_rs2_i = 32'h01010101;
      issue_id_i = IDW'(nis);
      result_ready_i = (c >= 5);
      #1;
      if (c == 2) begin
        chk("bp_ready_low", {31'd0, issue_ready_o}, 32'd0);
        chk("bp_accepted", nis, 32'd2);
      end
      if (c >= 2 && c <= 4) begin
        chk("bp_hold_valid", {31'd0, result_valid_o}, 32'd1);
        chk("bp_hold_data", result_data_o, 32'd4);
      end
      if (result_valid_o && result_ready_i) begin
        chk("bp_data", result_data_o, 32'(4 * (nres + 1)));
        chk("bp_id", {28'd0, result_id_o}, 32'(nres));
        chk("bp_rd", {27'd0, result_rd_o}, 32'(10 + nres));
        nres++;
      end
      if (issue_valid_i && issue_ready_o) nis++;
    end
    issue_valid_i = 1'b0;
    result_ready_i = 1'b1;
    chk("bp_count", nres, 32'd4);
    // flush: first DOTPACC already in S2 (acc 4 -> 8), second still in S1 and must not add 10
    @(negedge clk);
    result_ready_i = 1'b0;
    issue_instr_i = mk(7'd1, 5'd6);
    issue_rs1_i = 32'h01010101;
    issue_rs2_i = 32'h01010101;
    issue_id_i = 4'd1;
    issue_valid_i = 1'b1;
    @(negedge clk);
    issue_rs1_i = 32'h04030201;
    issue_id_i = 4'd2;
    @(negedge clk);
    issue_valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush_ready", {31'd0, issue_ready_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    result_ready_i = 1'b1;
    seen = result_valid_o;
    repeat (3) begin
      @(negedge clk);
      seen |= result_valid_o;
    end
    chk("flush_dropped", {31'd0, seen}, 32'd0);
    run_op("flush_acc", 7'd1, 32'h01010101, 32'h01010101, 5'd6, 4'd3, 32'd12);
    run_op("big_clr", 7'd2, 32'h0, 32'h0, 5'd1, 4'd0, 32'd12);
`ifdef CVXIF_DOTP_SAT_EN
    big_exp = 32'h7FFFFFFF;
`else
    big_exp = 32'h800DB850;
`endif
    issue_instr_i = mk(7'd1, 5'd9);
    issue_rs1_i = 32'h7F7F7F7F;
    issue_rs2_i = 32'h7F7F7F7F;
    issue_id_i = 4'd5;
    nis = 0;
    nres = 0;
    first = '0;
    last = '0;
    for (int c = 0; c < 34000 && nres < 33300; c++) begin
      @(negedge clk);
      issue_valid_i = (nis < 33300);
      #1;
      if (result_valid_o) begin
        if (nres == 0) first = result_data_o;
        last = result_data_o;
        nres++;
      end
      if (issue_valid_i && issue_ready_o) nis++;
    end
    issue_valid_i = 1'b0;
    chk("big_first", first, 32'd64516);
    chk("big_count", nres, 32'd33300);
    chk("big_final", last, big_exp);
    // reset mid-operation
    @(negedge clk);
    issue_instr_i = mk(7'd1, 5'd2);
    issue_rs1_i = 32'h01010101;
    issue_rs2_i = 32'h01010101;
    issue_valid_i = 1'b1;
    @(negedge clk);
    issue_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, result_valid_o}, 32'd0);
    chk("mrst_ready", {31'd0, issue_ready_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= result_valid_o;
    end
    chk("mrst_lost", {31'd0, seen}, 32'd0);
    run_op("mrst_acc", 7'd2, 32'h0, 32'h0, 5'd3, 4'd9, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
